// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer RAM.
package vga_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT,
    W_WRITE,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_RESP
  } r_state_t;

endpackage

// File: rtl/vga_fb_mem.sv
// True dual-port framebuffer storage. Port A: read/write with per-pixel
// write enables, read-first. Port B: registered read-only. No handshake logic.
module vga_fb_mem #(
  parameter int PIXEL_WIDTH     = 12,
  parameter int PIXELS_PER_WORD = 2,
  parameter int DEPTH           = 38400,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                                   clk,
  input  logic [ADDR_WIDTH-1:0]                  i_a_addr,
  input  logic [PIXELS_PER_WORD-1:0]             i_a_we,
  input  logic                                   i_a_re,
  input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] i_a_wdata,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] o_a_rdata,
  input  logic [ADDR_WIDTH-1:0]                  i_b_addr,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] o_b_rdata
);

  localparam int W = PIXEL_WIDTH * PIXELS_PER_WORD;

  logic [W-1:0] r_mem [0:DEPTH-1];
  logic [W-1:0] r_a_rdata;
  logic [W-1:0] r_b_rdata;

  // Port A: the read register only loads when a read is requested, so it
  // holds the last requested word; writes are pixel-granular.
  always_ff @(posedge clk) begin
    if (i_a_re) begin
      r_a_rdata <= r_mem[i_a_addr];
    end
    for (int p = 0; p < PIXELS_PER_WORD; p++) begin
      if (i_a_we[p]) begin
        r_mem[i_a_addr][p*PIXEL_WIDTH +: PIXEL_WIDTH] <= i_a_wdata[p*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

  // Port B: free-running registered read for the scan-out pipeline.
  always_ff @(posedge clk) begin
    r_b_rdata <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/vga_fb_ram.sv
// Framebuffer RAM: AXI-lite style CPU slave on port A, video read on port B.
module vga_fb_ram
  import vga_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 12,
  parameter int PIXELS_PER_WORD = 2,
  parameter int DEPTH           = 38400,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDR_WIDTH-1:0]                  awaddr,
  input  logic [2:0]                             awprot,
  input  logic                                   awvalid,
  output logic                                   awready,
  input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] wdata,
  input  logic [PIXELS_PER_WORD-1:0]             wstrb,
  input  logic                                   wvalid,
  output logic                                   wready,
  output logic [1:0]                             bresp,
  output logic                                   bvalid,
  input  logic                                   bready,
  input  logic [ADDR_WIDTH-1:0]                  araddr,
  input  logic [2:0]                             arprot,
  input  logic                                   arvalid,
  output logic                                   arready,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] rdata,
  output logic [1:0]                             rresp,
  output logic                                   rvalid,
  input  logic                                   rready,
  input  logic [ADDR_WIDTH-1:0]                  vaddr,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] vdata
);

  localparam int W = PIXEL_WIDTH * PIXELS_PER_WORD;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  // Protection bits carry no meaning for a framebuffer.
  logic w_unused_prot;
  assign w_unused_prot = ^{awprot, arprot};

  // ---------------- write channel ----------------
  w_state_t                  r_w_state, w_w_state_next;
  logic                      r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0]     r_awaddr;
  logic [W-1:0]              r_wdata;
  logic [PIXELS_PER_WORD-1:0] r_wstrb;
  logic [1:0]                r_bresp;
  logic                      w_aw_hs, w_w_hs, w_wr_in_range;
  logic [PIXELS_PER_WORD-1:0] w_we;

  assign w_wr_in_range = ({1'b0, r_awaddr} < DEPTH_LIM);

  // Write FSM next state and channel outputs.
  always_comb begin
    w_w_state_next = r_w_state;
    awready        = 1'b0;
    wready         = 1'b0;
    bvalid         = 1'b0;
    w_we           = '0;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    case (r_w_state)
      W_COLLECT: begin
        awready = !r_aw_held;
        wready  = !r_w_held;
        w_aw_hs = awvalid && !r_aw_held;
        w_w_hs  = wvalid && !r_w_held;
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_w_state_next = W_WRITE;
        end
      end
      W_WRITE: begin
        // A reset landing on this cycle must not commit the write.
        if (!rst && w_wr_in_range) begin
          w_we = r_wstrb;
        end
        w_w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_w_state_next = W_COLLECT;
        end
      end
      default: w_w_state_next = W_COLLECT;
    endcase
  end

  // Write FSM state plus held address/data/strobe and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_state <= W_COLLECT;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_w_state <= w_w_state_next;
      if (w_aw_hs) begin
        r_awaddr  <= awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
        r_w_held <= 1'b1;
      end
      if (r_w_state == W_WRITE) begin
        r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_w_state == W_RESP && bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign bresp = r_bresp;

  // ---------------- read channel ----------------
  r_state_t              r_r_state, w_r_state_next;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_rd_issued;
  logic [W-1:0]          r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_re, w_rd_in_range;
  logic [W-1:0]          w_a_rdata;

  assign w_rd_in_range = ({1'b0, r_araddr} < DEPTH_LIM);

  // Read FSM: R_READ spends one cycle issuing the RAM read (retried while a
  // write owns port A) and one cycle registering the result.
  always_comb begin
    w_r_state_next = r_r_state;
    arready        = 1'b0;
    rvalid         = 1'b0;
    w_re           = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          w_r_state_next = R_READ;
        end
      end
      R_READ: begin
        if (!r_rd_issued) begin
          w_re = (r_w_state != W_WRITE);
        end else begin
          w_r_state_next = R_RESP;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          w_r_state_next = R_IDLE;
        end
      end
      default: w_r_state_next = R_IDLE;
    endcase
  end

  // Read FSM state, captured address and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r_state   <= R_IDLE;
      r_araddr    <= '0;
      r_rd_issued <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
    end else begin
      r_r_state <= w_r_state_next;
      if (r_r_state == R_IDLE && arvalid) begin
        r_araddr <= araddr;
      end
      if (w_re) begin
        r_rd_issued <= 1'b1;
      end else if (r_r_state == R_READ && r_rd_issued) begin
        r_rd_issued <= 1'b0;
        r_rdata     <= w_rd_in_range ? w_a_rdata : '0;
        r_rresp     <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign rdata = r_rdata;
  assign rresp = r_rresp;

  // ---------------- video port ----------------
  logic         r_v_in_range;
  logic [W-1:0] w_b_rdata;

  // Track whether last cycle's video address was valid so stray addresses read as black.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_in_range <= 1'b0;
    end else begin
      r_v_in_range <= ({1'b0, vaddr} < DEPTH_LIM);
    end
  end

  assign vdata = r_v_in_range ? w_b_rdata : '0;

  // ---------------- storage ----------------
  logic [ADDR_WIDTH-1:0] w_a_addr;
  assign w_a_addr = (r_w_state == W_WRITE) ? r_awaddr : r_araddr;

  vga_fb_mem #(
    .PIXEL_WIDTH     (PIXEL_WIDTH),
    .PIXELS_PER_WORD (PIXELS_PER_WORD),
    .DEPTH           (DEPTH),
    .ADDR_WIDTH      (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_a_addr  (w_a_addr),
    .i_a_we    (w_we),
    .i_a_re    (w_re),
    .i_a_wdata (r_wdata),
    .o_a_rdata (w_a_rdata),
    .i_b_addr  (vaddr),
    .o_b_rdata (w_b_rdata)
  );

endmodule

// File: tb/tb_vga_fb_ram.sv
// Self-checking bench for vga_fb_ram against a word/pixel memory model.
module tb_vga_fb_ram;

  localparam int DEPTH = 38400;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [23:0] wdata;
  logic [1:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [15:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [23:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [15:0] vaddr;
  logic [23:0] vdata;

  vga_fb_ram dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .vaddr(vaddr), .vdata(vdata)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] mdl [int];   // word model, only addresses ever written
  bit          vchk_en = 1'b0;
  int          v_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] merge(input logic [23:0] old, input logic [23:0] nw,
                                        input logic [1:0] s);
    logic [23:0] res;
    res = old;
    for (int p = 0; p < 2; p++) if (s[p]) res[p*12 +: 12] = nw[p*12 +: 12];
    return res;
  endfunction

  function automatic logic [15:0] vsweep(input int n);
    int m;
    m = n % 20;
    if (m < 16) return 16'(m);
    if (m == 16) return 16'd38400;
    if (m == 17) return 16'hFFFF;
    if (m == 18) return 16'd38399;
    return 16'd0;
  endfunction

  // Advance one clock; the video port is checked against the model as it was before the edge.
  task automatic tick();
    logic [23:0] ev;
    bit          en;
    en = vchk_en;
    ev = '0;
    if (int'(vaddr) >= DEPTH) ev = '0;
    else if (mdl.exists(int'(vaddr))) ev = mdl[int'(vaddr)];
    else en = 1'b0;
    @(posedge clk);
    #1;
    if (en) chk("vdata", 32'(vdata), 32'(ev));
    v_cnt++;
    vaddr = vsweep(v_cnt);
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [23:0] d, input logic [1:0] s,
                           input int aw_dly, input int w_dly, input int bready_dly);
    bit aw_done, w_done, hs_aw, hs_w;
    int c;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; c = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && c < 50) begin
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      aw_done |= hs_aw;
      w_done  |= hs_w;
      c++;
    end
    chk("wr_accept", 32'(aw_done && w_done), 1);
    awvalid = 0; wvalid = 0;
    tick();
    exp_resp = (int'(a) >= DEPTH) ? 2'b10 : 2'b00;
    if (int'(a) < DEPTH && s != 2'b00)
      mdl[int'(a)] = merge(mdl.exists(int'(a)) ? mdl[int'(a)] : 24'hxxxxxx, d, s);
    chk("bvalid_lat", 32'(bvalid), 1);
    chk("bresp", 32'(bresp), 32'(exp_resp));
    for (int i = 0; i < bready_dly; i++) begin
      awvalid = 1; wvalid = 1; awaddr = a ^ 16'h0001; wdata = ~d;
      chk("awready_hold", 32'(awready), 0);
      chk("wready_hold", 32'(wready), 0);
      tick();
      chk("bvalid_hold", 32'(bvalid), 1);
      chk("bresp_hold", 32'(bresp), 32'(exp_resp));
    end
    awvalid = 0; wvalid = 0;
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_drop", 32'(bvalid), 0);
    chk("awready_back", 32'(awready), 1);
    chk("wready_back", 32'(wready), 1);
    $display("write addr=%0d data=%h strb=%b resp=%b", a, d, s, exp_resp);
  endtask

  task automatic read_txn(input logic [15:0] a, input int rready_dly, input int exp_lat);
    int lat;
    logic [23:0] exp_d;
    logic [1:0]  exp_r;
    araddr = a; arvalid = 1;
    chk("arready_idle", 32'(arready), 1);
    tick();
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    chk("rd_latency", lat, exp_lat);
    if (int'(a) >= DEPTH) begin
      exp_d = '0; exp_r = 2'b10;
    end else begin
      exp_d = mdl.exists(int'(a)) ? mdl[int'(a)] : 24'hxxxxxx;
      exp_r = 2'b00;
    end
    chk("rdata", 32'(rdata), 32'(exp_d));
    chk("rresp", 32'(rresp), 32'(exp_r));
    for (int i = 0; i < rready_dly; i++) begin
      arvalid = 1; araddr = a ^ 16'h0003;
      tick();
      chk("rvalid_hold", 32'(rvalid), 1);
      chk("rdata_hold", 32'(rdata), 32'(exp_d));
      chk("arready_hold", 32'(arready), 0);
    end
    arvalid = 0;
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_drop", 32'(rvalid), 0);
    chk("arready_back", 32'(arready), 1);
    $display("read  addr=%0d data=%h resp=%b lat=%0d", a, rdata, rresp, lat);
  endtask

  initial begin
    logic [23:0] d, d2;
    int lat;
    rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0; vaddr = 0;
    tick(); tick();
    chk("rst_awready", 32'(awready), 1);
    chk("rst_wready", 32'(wready), 1);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_vdata", 32'(vdata), 0);
    rst = 0;
    vchk_en = 1;

    // Fill the swept region plus the last valid word.
    for (int k = 0; k < 16; k++)
      write_txn(16'(k), 24'($urandom), 2'b11, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    write_txn(16'd38399, 24'($urandom), 2'b11, 1, 0, 0);
    read_txn(16'd38399, 0, 2);

    // W three cycles after AW, then full and partial writes to the same word.
    write_txn(16'd5, 24'hABC123, 2'b11, 0, 3, 0);
    read_txn(16'd5, 0, 2);
    write_txn(16'd5, 24'h000FFF, 2'b01, 0, 0, 0);
    read_txn(16'd5, 0, 2);
    chk("partial_const", 32'(rdata), 32'h00ABCFFF);
    write_txn(16'd6, 24'h5A5A5A, 2'b00, 0, 0, 0);
    read_txn(16'd6, 0, 2);

    // Out-of-range accesses.
    write_txn(16'd38400, 24'h123456, 2'b11, 0, 0, 0);
    write_txn(16'hFFFF, 24'h654321, 2'b11, 2, 1, 0);
    read_txn(16'd40000, 0, 2);
    read_txn(16'd38399, 0, 2);

    // Back-pressure on both responses.
    write_txn(16'd10, 24'($urandom), 2'b11, 2, 0, 10);
    read_txn(16'd10, 10, 2);

    // AR accepted together with AW/W: the read collides with W_WRITE.
    d = 24'($urandom);
    awaddr = 9; wdata = d; wstrb = 2'b11; awvalid = 1; wvalid = 1;
    araddr = 3; arvalid = 1; bready = 1;
    chk("coll_awready", 32'(awready), 1);
    chk("coll_arready", 32'(arready), 1);
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin
        mdl[9] = d;
        chk("coll_bvalid", 32'(bvalid), 1);
      end
    end
    chk("coll_rd_latency", lat, 3);
    chk("coll_rdata", 32'(rdata), 32'(mdl[3]));
    rready = 1;
    tick();
    rready = 0; bready = 0;
    chk("coll_rvalid_drop", 32'(rvalid), 0);
    chk("coll_bvalid_drop", 32'(bvalid), 0);
    read_txn(16'd9, 0, 2);
    $display("collide write9 read3 lat=%0d", lat);

    // Reset while the write sits in W_RESP and the read in R_READ.
    d = 24'($urandom);
    awaddr = 7; wdata = d; wstrb = 2'b11; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    mdl[7] = d;
    chk("mid_bvalid", 32'(bvalid), 1);
    araddr = 7; arvalid = 1;
    tick();
    arvalid = 0;
    vchk_en = 0; rst = 1;
    tick();
    rst = 0;
    chk("mrst_bvalid", 32'(bvalid), 0);
    chk("mrst_rvalid", 32'(rvalid), 0);
    chk("mrst_awready", 32'(awready), 1);
    chk("mrst_wready", 32'(wready), 1);
    chk("mrst_arready", 32'(arready), 1);
    chk("mrst_bresp", 32'(bresp), 0);
    chk("mrst_rdata", 32'(rdata), 0);
    chk("mrst_vdata", 32'(vdata), 0);
    vchk_en = 1;
    $display("reset in W_RESP/R_READ");

    // Reset while the write is in W_WRITE: word 8 must keep its old value.
    d2 = ~mdl[8];
    awaddr = 8; wdata = d2; wstrb = 2'b11; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    vchk_en = 0; rst = 1;
    tick();
    rst = 0;
    chk("wrst_bvalid", 32'(bvalid), 0);
    vchk_en = 1;
    read_txn(16'd8, 0, 2);
    read_txn(16'd7, 0, 2);

    // Randomized traffic over the swept region.
    for (int k = 0; k < 16; k++) begin
      write_txn(16'($urandom_range(0, 15)), 24'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      read_txn(16'($urandom_range(0, 15)), $urandom_range(0, 3), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_ram.md
Name: vga_fb_ram

Overview:
Parametrised framebuffer RAM for the VGA subsystem.
- CPU side: AXI-lite style slave with full write and read channels, per-pixel write strobes, packed multi-pixel words, and OKAY/SLVERR responses.
- Video side: free-running read port with fixed 1-cycle latency, feeding the scan-out pipeline.

Parameters:
PIXEL_WIDTH, 12, bits per pixel (4:4:4 RGB)
PIXELS_PER_WORD, 2, pixels packed per memory word; word width W = PIXEL_WIDTH*PIXELS_PER_WORD
DEPTH, 38400, number of valid words (320x240 / 2)
ADDR_WIDTH, 16, word-address width; requires DEPTH <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
awaddr  in  ADDR_WIDTH  write word address
awprot  in  3  ignored
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  W  write data; pixel i = wdata[i*PIXEL_WIDTH +: PIXEL_WIDTH]
wstrb  in  PIXELS_PER_WORD  per-pixel write enable
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  CPU read word address
arprot  in  3  ignored
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  W  CPU read data
rresp  out  2  read response
rvalid  out  1  read response valid
rready  in  1  read response ready
vaddr  in  ADDR_WIDTH  video read word address
vdata  out  W  video read data

Behaviour:
- Reset values:
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, vdata=0.
  - Reset clears any held address/data/strobe. Memory contents are not reset.
- Write FSM, states W_COLLECT, W_WRITE, W_RESP:
  - W_COLLECT: awready=!aw_held, wready=!w_held. Each channel is captured on its valid&ready. AW and W are independent and may arrive in the same cycle or either order.
  - Once both are held, go to W_WRITE.
  - W_WRITE: assert the port-A write for one cycle, writing only the pixels whose wstrb bit is 1.
    - If addr >= DEPTH, no write occurs and bresp=SLVERR (2'b10); otherwise OKAY.
    - wstrb=0 is legal: no write, OKAY.
    - Next state: W_RESP.
  - W_RESP: bvalid=1 and bresp stable until bready. On bvalid&bready, return to W_COLLECT with held flags cleared. awready=wready=0 throughout W_WRITE and W_RESP.
  - Latency: with AW and W both accepted at edge N, memory updates at edge N+1 and bvalid is high from N+1. One transaction in flight at a time.
- Read FSM, states R_IDLE, R_READ, R_RESP:
  - R_IDLE: arready=1. On arvalid, capture araddr and go to R_READ.
  - R_READ: port-A read is issued.
    - If the write FSM is in W_WRITE in the same cycle, the write wins and the read stays in R_READ one more cycle.
    - Otherwise go to R_RESP with data registered.
  - R_RESP: rvalid=1 with rdata and rresp stable until rready.
    - addr >= DEPTH: rdata=0, rresp=SLVERR.
    - Next state on rvalid&rready: R_IDLE. arready=0 outside R_IDLE.
  - Minimum read latency: AR accepted at edge N gives rvalid high from N+2.
- Read-after-write: a read whose AR handshake occurs after the write's bvalid&bready returns the new data.
- Video port (port B, read-only):
  - vdata <= mem[vaddr] every cycle, 1-cycle latency, never stalls.
  - vaddr >= DEPTH gives vdata=0.
  - If port B reads the word being written in the same cycle, vdata returns old data (read-first).
- Reset mid-operation: a pending write is dropped with no memory update, and the pending read is dropped. Both FSMs return to their idle states.

Decomposition:
- Package vga_pkg:
  - resp constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - enums: w_state_t {W_COLLECT, W_WRITE, W_RESP} and r_state_t {R_IDLE, R_READ, R_RESP}.
- Sub-module vga_fb_mem: true dual-port block RAM, DEPTH x W.
  - Port A: read/write with per-pixel write enable, read-first.
  - Port B: registered read-only.
  - Written for BRAM inference; holds no handshake logic.

Test Plan:
- AW at cycle 0, W at cycle 3, addr=5, wdata=24'hABC123, wstrb=2'b11, bready=1 -> bvalid one cycle later with bresp=0; then AR addr=5 -> rdata=24'hABC123, rresp=0, rvalid 2 cycles after AR.
- Write addr=5, wdata=24'h000FFF, wstrb=2'b01 over the prior value -> read returns 24'hABCFFF.
- AW and W same cycle, addr=38400 -> bresp=2'b10 and memory unchanged. AR addr=40000 -> rdata=0, rresp=2'b10.
- bready held low 10 cycles -> bvalid and bresp stable, awready=wready=0 for the whole window, no second write accepted. Same check for rvalid with rready low.
- AR arrives while the FSM is in W_WRITE -> read delayed exactly one cycle. Video port sweeping vaddr 0..15 concurrently -> vdata matches the memory model with 1-cycle latency and no stall.
- Assert rst while in W_RESP and R_READ -> next cycle: bvalid=0, rvalid=0, all readies=1, no spurious memory write.
